vga_draw_arbiter: RTL



---
 rtl/vga_draw_arbiter_pkg.sv | 42 ++++
 rtl/vga_draw_arbiter_cell_pixel_counter.sv | 45 ++++
 rtl/vga_draw_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// rtl/vga_draw_arbiter_pkg.sv - shared types and constants for the VGA draw arbiter
package vga_draw_arbiter_pkg;

    localparam logic [2:0] COL_WALL  = 3'b000;
    localparam logic [2:0] COL_PATH  = 3'b111;
    localparam logic [2:0] COL_START = 3'b010;
    localparam logic [2:0] COL_EXIT  = 3'b100;
    localparam logic [2:0] COL_OTHER = 3'b001;

    localparam logic [2:0] MEM_WALL  = 3'd0;
    localparam logic [2:0] MEM_PATH  = 3'd1;
    localparam logic [2:0] MEM_START = 3'd2;
    localparam logic [2:0] MEM_EXIT  = 3'd3;

    typedef enum logic [1:0] {
        JOB_MAZE,
        JOB_ERASE,
        JOB_DRAW
    } job_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAITRD,
        FILL,
        NEXT,
        DONE,
        RELEASE
    } state_t;

    // Maze memory code to pixel colour; codes 4-7 are reserved and all draw as COL_OTHER.
    function automatic logic [2:0] cell_colour(input logic [2:0] code);
        case (code)
            MEM_WALL:  return COL_WALL;
            MEM_PATH:  return COL_PATH;
            MEM_START: return COL_START;
            MEM_EXIT:  return COL_EXIT;
            default:   return COL_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_cell_pixel_counter.sv
// rtl/vga_draw_arbiter_cell_pixel_counter.sv - sweeps one grid cell into CELL x CELL pixel coordinates
module cell_pixel_counter #(
    parameter int CELL = 4,
    parameter int X0   = 40,
    parameter int Y0   = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    input  logic [4:0] cx,
    input  logic [4:0] cy,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic       last
);

    localparam int FW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam logic [FW-1:0] EDGE = FW'(CELL - 1);

    logic [FW-1:0] fx;
    logic [FW-1:0] fy;
    logic          fx_wrap;

    assign fx_wrap = (fx == EDGE);
    assign last    = fx_wrap && (fy == EDGE);

    // A full sweep wraps both counters back to zero, so the next cell starts clean.
    always_ff @(posedge clock) begin
        if (reset) begin
            fx <= '0;
            fy <= '0;
        end else if (advance) begin
            if (fx_wrap) begin
                fx <= '0;
                fy <= (fy == EDGE) ? '0 : fy + FW'(1);
            end else begin
                fx <= fx + FW'(1);
            end
        end
    end

    assign px = 8'(X0) + 8'(cx) * 8'(CELL) + 8'(fx);
    assign py = 7'(Y0) + 7'(cy) * 7'(CELL) + 7'(fy);

endmodule

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - fixed-priority owner of the VGA pixel port and the maze memory read port
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int         CELL          = 4,
    parameter int         GRID_W        = 20,
    parameter int         GRID_H        = 20,
    parameter int         X0            = 40,
    parameter int         Y0            = 20,
    parameter logic [2:0] PLAYER_COLOUR = 3'b110
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw_maze,
    input  logic       erase_box,
    input  logic       draw_box,
    input  logic [4:0] draw_x,
    input  logic [4:0] draw_y,
    input  logic [4:0] prev_x,
    input  logic [4:0] prev_y,
    input  logic [2:0] mem_data,
    output logic [8:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_busy,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       done_maze,
    output logic       done_erase,
    output logic       done_draw
);

    state_t     state;
    job_t       job;
    logic [4:0] cx;
    logic [4:0] cy;
    logic [2:0] colour;
    logic [7:0] px;
    logic [6:0] py;
    logic       last_pixel;
    logic       erase_ok;
    logic       draw_ok;
    logic       held;

    cell_pixel_counter #(
        .CELL (CELL),
        .X0   (X0),
        .Y0   (Y0)
    ) u_counter (
        .clock   (clock),
        .reset   (reset),
        .advance (state == FILL),
        .cx      (cx),
        .cy      (cy),
        .px      (px),
        .py      (py),
        .last    (last_pixel)
    );

    assign erase_ok = (int'(prev_x) < GRID_W) && (int'(prev_y) < GRID_H);
    assign draw_ok  = (int'(draw_x) < GRID_W) && (int'(draw_y) < GRID_H);

    // RELEASE waits on whichever request was granted, so a held level is not served twice.
    always_comb begin
        held = 1'b0;
        case (job)
            JOB_MAZE:  held = draw_maze;
            JOB_ERASE: held = erase_box;
            default:   held = draw_box;
        endcase
    end

    assign mem_rd   = (state == RD);
    assign mem_busy = (state != IDLE);
    assign mem_addr = mem_rd ? (9'(cy) * 9'(GRID_W) + 9'(cx)) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            job        <= JOB_MAZE;
            cx         <= '0;
            cy         <= '0;
            colour     <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            done_maze  <= 1'b0;
            done_erase <= 1'b0;
            done_draw  <= 1'b0;
        end else begin
            plot       <= 1'b0;
            done_maze  <= 1'b0;
            done_erase <= 1'b0;
            done_draw  <= 1'b0;
            case (state)
                IDLE: begin
                    if (draw_maze) begin
                        job   <= JOB_MAZE;
                        cx    <= '0;
                        cy    <= '0;
                        state <= RD;
                    end else if (erase_box) begin
                        job   <= JOB_ERASE;
                        cx    <= prev_x;
                        cy    <= prev_y;
                        state <= erase_ok ? RD : DONE;
                    end else if (draw_box) begin
                        job    <= JOB_DRAW;
                        cx     <= draw_x;
                        cy     <= draw_y;
                        colour <= PLAYER_COLOUR;
                        state  <= draw_ok ? FILL : DONE;
                    end
                end
                RD: state <= WAITRD;
                WAITRD: begin
                    colour <= cell_colour(mem_data);
                    state  <= FILL;
                end
                FILL: begin
                    plot       <= 1'b1;
                    vga_x      <= px;
                    vga_y      <= py;
                    vga_colour <= colour;
                    if (last_pixel) begin
                        state <= (job == JOB_MAZE) ? NEXT : DONE;
                    end
                end
                NEXT: begin
                    if (cx == 5'(GRID_W - 1)) begin
                        cx <= '0;
                        cy <= cy + 5'd1;
                        state <= (cy == 5'(GRID_H - 1)) ? DONE : RD;
                    end else begin
                        cx    <= cx + 5'd1;
                        state <= RD;
                    end
                end
                DONE: begin
                    case (job)
                        JOB_MAZE:  done_maze  <= 1'b1;
                        JOB_ERASE: done_erase <= 1'b1;
                        default:   done_draw  <= 1'b1;
                    endcase
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!held) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
